// File: rtl/target_io_ctrl.sv
// Target/timer controller: debounces sensors and button, runs two reaction-timer slots
// and the game countdown, and produces the words latched by the game register file.
module target_io_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int NUM_TARGETS  = 6,
  parameter int BASE_IDX     = 4,
  parameter int DEBOUNCE_MS  = 5,
  parameter int TIMEOUT_MS   = 2000,
  parameter int GAME_SECONDS = 60
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic [31:0]            t1active_read,
  input  logic [31:0]            t2active_read,
  input  logic [NUM_TARGETS-1:0] hit_sensor,
  input  logic                   button,
  input  logic                   game_start,
  output logic [NUM_TARGETS-1:0] target_led,
  output logic [31:0]            bp_write,
  output logic [31:0]            t1hit_write,
  output logic [31:0]            t2hit_write,
  output logic [31:0]            timer1_write,
  output logic [31:0]            timer2_write,
  output logic [31:0]            gametimer_write,
  output logic                   game_over
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NCH = NUM_TARGETS + 1;
  localparam int DW  = $clog2(DEBOUNCE_MS + 1);
  localparam int TW  = $clog2(TIMEOUT_MS + 1);
  localparam int GW  = $clog2(GAME_SECONDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HIT, S_EXPIRED} slot_state_t;

  logic [PW-1:0] presc_reg;
  logic [9:0]    ms_cnt_reg;
  logic          ms_tick, sec_tick;

  assign ms_tick  = (presc_reg == PW'(DIV - 1));
  assign sec_tick = ms_tick && (ms_cnt_reg == 10'd999);

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      presc_reg  <= '0;
      ms_cnt_reg <= '0;
    end else begin
      presc_reg <= ms_tick ? '0 : presc_reg + 1'b1;
      if (game_start)
        ms_cnt_reg <= '0;
      else if (ms_tick)
        ms_cnt_reg <= sec_tick ? '0 : ms_cnt_reg + 1'b1;
    end
  end

  // Channel NUM_TARGETS is the player button; the rest are hit sensors.
  logic [NCH-1:0]         raw_in, deb_level;
  logic [NUM_TARGETS-1:0] deb_prev_reg, hit_ev;

  assign raw_in = {button, hit_sensor};

  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_chan
    logic          s1_reg, s2_reg, deb_reg;
    logic [DW-1:0] cnt_reg;

    always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
        s1_reg  <= 1'b0;
        s2_reg  <= 1'b0;
        deb_reg <= 1'b0;
        cnt_reg <= '0;
      end else begin
        s1_reg <= raw_in[gi];
        s2_reg <= s1_reg;
        if (ms_tick) begin
          if (s2_reg != deb_reg) begin
            if (cnt_reg == DW'(DEBOUNCE_MS - 1)) begin
              deb_reg <= s2_reg;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end
    end

    assign deb_level[gi] = deb_reg;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) deb_prev_reg <= '0;
    else             deb_prev_reg <= deb_level[NUM_TARGETS-1:0];
  end

  assign hit_ev = deb_level[NUM_TARGETS-1:0] & ~deb_prev_reg;

  logic [3:0]    slot_idx   [2];
  logic [3:0]    slot_prev  [2];
  logic [TW-1:0] slot_timer [2];
  logic [1:0]    slot_armed, slot_hit, slot_exp;

  assign slot_idx[0] = t1active_read[3:0];
  assign slot_idx[1] = t2active_read[3:0];

  for (gi = 0; gi < 2; gi++) begin : g_slot
    slot_state_t            state_reg;
    logic [3:0]             prev_reg;
    logic                   hit_reg, exp_reg;
    logic [TW-1:0]          timer_reg;
    logic [NUM_TARGETS-1:0] match;
    logic                   idx_valid, idx_change, slot_hit_ev;

    always_comb begin
      match = '0;
      for (int i = 0; i < NUM_TARGETS; i++)
        match[i] = (slot_idx[gi] == 4'(BASE_IDX + i));
    end

    assign idx_valid   = |match;
    assign idx_change  = (slot_idx[gi] != prev_reg);
    assign slot_hit_ev = |(match & hit_ev);

    // An index change overrides everything, including a same-cycle hit.
    always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
        state_reg <= S_IDLE;
        prev_reg  <= '0;
        hit_reg   <= 1'b0;
        exp_reg   <= 1'b0;
        timer_reg <= '0;
      end else begin
        prev_reg <= slot_idx[gi];
        if (idx_change) begin
          state_reg <= idx_valid ? S_ARMED : S_IDLE;
          hit_reg   <= 1'b0;
          exp_reg   <= 1'b0;
          timer_reg <= '0;
        end else if (state_reg == S_ARMED) begin
          if (slot_hit_ev) begin
            state_reg <= S_HIT;
            hit_reg   <= 1'b1;
          end else if (ms_tick) begin
            timer_reg <= timer_reg + 1'b1;
            if (timer_reg == TW'(TIMEOUT_MS - 1)) begin
              state_reg <= S_EXPIRED;
              exp_reg   <= 1'b1;
            end
          end
        end
      end
    end

    assign slot_armed[gi] = (state_reg == S_ARMED);
    assign slot_prev[gi]  = prev_reg;
    assign slot_hit[gi]   = hit_reg;
    assign slot_exp[gi]   = exp_reg;
    assign slot_timer[gi] = timer_reg;
  end

  logic [NUM_TARGETS-1:0] led_next, led_reg;

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_TARGETS; i++)
      led_next[i] = (slot_armed[0] && slot_prev[0] == 4'(BASE_IDX + i)) ||
                    (slot_armed[1] && slot_prev[1] == 4'(BASE_IDX + i));
  end

  logic [GW-1:0] count_reg;
  logic          running_reg, over_reg;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      led_reg     <= '0;
      count_reg   <= '0;
      running_reg <= 1'b0;
      over_reg    <= 1'b0;
    end else begin
      led_reg <= led_next;
      if (game_start) begin
        count_reg   <= GW'(GAME_SECONDS);
        running_reg <= 1'b1;
        over_reg    <= 1'b0;
      end else if (running_reg && sec_tick) begin
        if (count_reg <= GW'(1)) begin
          count_reg   <= '0;
          running_reg <= 1'b0;
          over_reg    <= 1'b1;
        end else begin
          count_reg <= count_reg - 1'b1;
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{t1active_read[31:4], t2active_read[31:4]};

  assign target_led      = led_reg;
  assign bp_write        = {31'b0, deb_level[NUM_TARGETS]};
  assign t1hit_write     = {30'b0, slot_exp[0], slot_hit[0]};
  assign t2hit_write     = {30'b0, slot_exp[1], slot_hit[1]};
  assign timer1_write    = {{(32-TW){1'b0}}, slot_timer[0]};
  assign timer2_write    = {{(32-TW){1'b0}}, slot_timer[1]};
  assign gametimer_write = {{(32-GW){1'b0}}, count_reg};
  assign game_over       = over_reg;

endmodule

// File: tb/tb_target_io_ctrl.sv
// Bench for target_io_ctrl at CLK_HZ=1000 (one cycle per ms), directed steps plus a
// randomized phase, compared against a timestamp-based behavioural model.
module tb_target_io_ctrl;
  localparam int NT   = 6;
  localparam int BASE = 4;
  localparam int TO   = 2000;
  localparam int GS   = 60;

  logic          clock = 1'b0;
  logic          ctrl_reset = 1'b0;
  logic [31:0]   t1active = '0, t2active = '0;
  logic [NT-1:0] hit_sensor = '0;
  logic          button = 1'b0, game_start = 1'b0;
  logic [NT-1:0] target_led;
  logic [31:0]   bp_write, t1hit_write, t2hit_write, timer1_write, timer2_write, gametimer_write;
  logic          game_over;

  int checks = 0;
  int errors = 0;

  target_io_ctrl #(.CLK_HZ(1000)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .t1active_read(t1active), .t2active_read(t2active),
    .hit_sensor(hit_sensor), .button(button), .game_start(game_start),
    .target_led(target_led), .bp_write(bp_write),
    .t1hit_write(t1hit_write), .t2hit_write(t2hit_write),
    .timer1_write(timer1_write), .timer2_write(timer2_write),
    .gametimer_write(gametimer_write), .game_over(game_over)
  );

  always #5 clock = ~clock;

  // Model: raw-sample history, debounced levels, and per-slot status with arm timestamps.
  int unsigned   edge_n;
  logic [NT:0]   hist [8];
  logic [NT:0]   mdeb, mdeb_prev;
  int            mst [2];   // 0 idle, 1 armed, 2 hit, 3 expired
  int            marm [2];
  int            mfrz [2];
  logic [3:0]    mprev [2];
  logic [NT-1:0] mled;
  int            gs_edge;
  bit            gs_started;

  task automatic model_reset();
    edge_n = 16;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    mdeb = '0; mdeb_prev = '0; mled = '0;
    for (int s = 0; s < 2; s++) begin
      mst[s] = 0; marm[s] = 0; mfrz[s] = 0; mprev[s] = '0;
    end
    gs_edge = 0; gs_started = 0;
  endtask

  task automatic model_step();
    logic [NT-1:0] hev, led_n;
    logic [3:0]    idx;
    int            ii;
    bit            all_diff;
    edge_n++;
    hist[edge_n % 8] = {button, hit_sensor};
    hev = mdeb[NT-1:0] & ~mdeb_prev[NT-1:0];
    led_n = '0;
    for (int s = 0; s < 2; s++)
      if (mst[s] == 1) begin
        ii = int'(mprev[s]) - BASE;
        led_n[ii] = 1'b1;
      end
    for (int s = 0; s < 2; s++) begin
      idx = (s == 0) ? t1active[3:0] : t2active[3:0];
      ii  = int'(idx) - BASE;
      if (idx != mprev[s]) begin
        if (ii >= 0 && ii < NT) begin
          mst[s] = 1; marm[s] = int'(edge_n);
        end else begin
          mst[s] = 0;
        end
      end else if (mst[s] == 1) begin
        if (hev[ii]) begin
          mst[s] = 2; mfrz[s] = int'(edge_n) - 1 - marm[s];
        end else if (int'(edge_n) - marm[s] == TO) begin
          mst[s] = 3;
        end
      end
      mprev[s] = idx;
    end
    mled = led_n;
    mdeb_prev = mdeb;
    // A level is accepted once the five synchronized samples before it all disagree.
    for (int ch = 0; ch <= NT; ch++) begin
      all_diff = 1;
      for (int k = 2; k <= 6; k++)
        if (hist[(edge_n - k) % 8][ch] == mdeb[ch]) all_diff = 0;
      if (all_diff) mdeb[ch] = ~mdeb[ch];
    end
    if (game_start) begin
      gs_edge = int'(edge_n); gs_started = 1;
    end
  endtask

  function automatic int exp_timer(int s);
    case (mst[s])
      1:       return int'(edge_n) - marm[s];
      2:       return mfrz[s];
      3:       return TO;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_gt();
    int k;
    if (!gs_started) return 0;
    k = (int'(edge_n) - gs_edge) / 1000;
    return (k >= GS) ? 0 : GS - k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_led"}, {26'b0, target_led}, {26'b0, mled});
    chk({tag, "_t1hit"}, t1hit_write, {30'b0, mst[0] == 3, mst[0] == 2});
    chk({tag, "_t2hit"}, t2hit_write, {30'b0, mst[1] == 3, mst[1] == 2});
    chk({tag, "_timer1"}, timer1_write, exp_timer(0));
    chk({tag, "_timer2"}, timer2_write, exp_timer(1));
    chk({tag, "_bp"}, bp_write, {31'b0, mdeb[NT]});
    chk({tag, "_gtimer"}, gametimer_write, exp_gt());
    chk({tag, "_gover"}, {31'b0, game_over},
        {31'b0, gs_started && (int'(edge_n) - gs_edge) >= GS * 1000});
  endtask

  task automatic run(input int n, input int stride, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_step();
      #1;
      if ((i % stride) == stride - 1 || i == n - 1) check_all(tag);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    $display("step: reset held");
    chk("rst_led", {26'b0, target_led}, 0);
    chk("rst_t1hit", t1hit_write, 0);
    chk("rst_timer2", timer2_write, 0);
    chk("rst_gtimer", gametimer_write, 0);
    chk("rst_gover", {31'b0, game_over}, 0);
    ctrl_reset = 1'b1;
    run(3, 1, "idle");

    $display("step: t1=4, sensor0 held 6 ms");
    t1active = 32'hABCD_0004; hit_sensor[0] = 1'b1;
    run(6, 1, "hold");
    chk("hold_led", {26'b0, target_led}, 1);
    hit_sensor[0] = 1'b0;
    run(4, 1, "hold_post");
    chk("hold_t1hit", t1hit_write, 1);
    chk("hold_timer_6to8", {31'b0, timer1_write >= 6 && timer1_write <= 8}, 1);
    run(10, 1, "settle");

    $display("step: re-arm t1=4, 3 ms glitch on sensor0");
    t1active = 0; run(1, 1, "rearm0");
    t1active = 4; run(2, 1, "rearm4");
    hit_sensor[0] = 1'b1; run(3, 1, "glitch");
    hit_sensor[0] = 1'b0; run(20, 1, "glitch_post");
    chk("glitch_t1hit", t1hit_write, 0);
    chk("glitch_led", {26'b0, target_led}, 1);

    $display("step: t1 idle, t2=9, wait for timeout");
    t1active = 0; t2active = 9;
    run(1, 1, "to_arm");
    run(1999, 100, "to_wait");
    chk("to_pre_t2hit", t2hit_write, 0);
    chk("to_pre_timer2", timer2_write, 1999);
    run(1, 1, "to_edge");
    chk("to_t2hit", t2hit_write, 2);
    chk("to_timer2", timer2_write, TO);
    run(1, 1, "to_led");
    chk("to_led_off", {26'b0, target_led}, 0);

    $display("step: t1=5 hit, then t1=6, then t1=15");
    t1active = 5; run(2, 1, "t5_arm");
    hit_sensor[1] = 1'b1; run(8, 1, "t5_hold");
    hit_sensor[1] = 1'b0; run(3, 1, "t5_post");
    chk("t5_t1hit", t1hit_write, 1);
    t1active = 6; run(1, 1, "t6");
    chk("t6_t1hit", t1hit_write, 0);
    chk("t6_timer1", timer1_write, 0);
    run(1, 1, "t6_led");
    chk("t6_led", {26'b0, target_led}, 6'b000100);
    t1active = 15; run(2, 1, "t15");
    chk("t15_led", {26'b0, target_led}, 0);
    chk("t15_t1hit", t1hit_write, 0);
    run(10, 1, "t15_settle");

    $display("step: randomized index/sensor/button traffic");
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(39) == 0) t1active = {$urandom_range(255), 4'($urandom_range(3, 11))};
      if ($urandom_range(39) == 0)
        t2active = ($urandom_range(2) == 0) ? t1active : 32'($urandom_range(2, 12));
      if ($urandom_range(7) == 0) hit_sensor[$urandom_range(NT - 1)] ^= 1'b1;
      if ($urandom_range(9) == 0) button = ~button;
      run(1, 1, "rnd");
    end
    t1active = 0; t2active = 0; hit_sensor = '0; button = 1'b0;
    run(12, 1, "rnd_end");

    $display("step: game countdown");
    game_start = 1'b1; run(1, 1, "gs");
    game_start = 1'b0;
    chk("gs_gtimer", gametimer_write, GS);
    chk("gs_gover", {31'b0, game_over}, 0);
    run(59999, 500, "count");
    chk("count_last", gametimer_write, 1);
    run(1, 1, "count_end");
    chk("count_zero", gametimer_write, 0);
    chk("count_gover", {31'b0, game_over}, 1);
    run(5, 1, "over_hold");
    game_start = 1'b1; run(1, 1, "gs2");
    game_start = 1'b0;
    chk("gs2_gtimer", gametimer_write, GS);
    chk("gs2_gover", {31'b0, game_over}, 0);

    $display("step: async reset while armed with debounce in progress");
    t1active = 4; run(2, 1, "pre_rst");
    hit_sensor[0] = 1'b1; button = 1'b1; run(3, 1, "pre_rst_deb");
    #2 ctrl_reset = 1'b0;
    #1;
    chk("arst_led", {26'b0, target_led}, 0);
    chk("arst_timer1", timer1_write, 0);
    chk("arst_gtimer", gametimer_write, 0);
    chk("arst_bp", bp_write, 0);
    t1active = 0; hit_sensor = '0; button = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 ctrl_reset = 1'b1;
    run(5, 1, "post_rst");
    chk("post_rst_led", {26'b0, target_led}, 0);
    chk("post_rst_timer1", timer1_write, 0);
    t1active = 4; run(2, 1, "rearm");
    chk("rearm_led", {26'b0, target_led}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
